// File: rtl/problema1_adc_serial_reader_if.sv
// Signal bundle between the AD0 serial reader and its surroundings:
// run control and the ADC pins on one side, the PIO-facing result on the other.
interface problema1_adc_serial_reader_if #(
  parameter int DATA_W = 8
);
  logic              enable;
  logic              adc_dout;
  logic              adc_cs_n;
  logic              adc_sclk;
  logic [DATA_W-1:0] data_out;
  logic              sample_valid;
  logic              busy;

  modport master (
    output enable, adc_dout,
    input  adc_cs_n, adc_sclk, data_out, sample_valid, busy
  );

  modport slave (
    input  enable, adc_dout,
    output adc_cs_n, adc_sclk, data_out, sample_valid, busy
  );
endinterface

// File: rtl/problema1_adc_serial_reader.sv
// Serial 8-bit ADC reader feeding the AD0 PIO; data_out only ever changes in DONE.
// Optional feature macro: ADC_AVG_EN (4-sample truncating average).
module problema1_adc_serial_reader #(
  parameter int CLK_DIV  = 4,
  parameter int DATA_W   = 8,
  parameter int CONV_GAP = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  problema1_adc_serial_reader_if.slave  bus
);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_MAX = (DATA_W > CONV_GAP) ? DATA_W : CONV_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_SETTLE = 3'd2,
    S_SHIFT  = 3'd3,
    S_DONE   = 3'd4,
    S_GAP    = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              cs_n_q, cs_n_d;
  logic              sclk_q, sclk_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              tick;
  logic              done_entry;
`ifdef ADC_AVG_EN
  logic [1:0]        avg_cnt_q, avg_cnt_d;
  logic [DATA_W+1:0] acc_q, acc_d;
  logic [DATA_W+1:0] acc_sum;
`endif

  assign tick = (div_q == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // cnt_q counts captured bits in SHIFT and idle cycles in GAP
  always_comb begin
    state_d = state_q;
    sclk_d  = sclk_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    case (state_q)
      S_IDLE: begin
        sclk_d = 1'b0;
        if (bus.enable) state_d = S_START;
        else            state_d = S_IDLE;
      end
      S_START: begin
        if (tick) begin
          state_d = S_SETTLE;
          sclk_d  = 1'b1;
        end else begin
          sclk_d  = 1'b0;
        end
      end
      S_SETTLE: begin
        if (tick && sclk_q) begin
          sclk_d = 1'b0;
        end else if (tick) begin
          state_d = S_SHIFT;
          sclk_d  = 1'b1;
        end else begin
          sclk_d = sclk_q;
        end
      end
      S_SHIFT: begin
        if (tick && sclk_q) begin
          sclk_d  = 1'b0;
          shift_d = {shift_q[DATA_W-2:0], bus.adc_dout};
          cnt_d   = cnt_q + CNT_W'(1);
        end else if (tick && (cnt_q == CNT_W'(DATA_W))) begin
          state_d = S_DONE;
        end else if (tick) begin
          sclk_d = 1'b1;
        end else begin
          sclk_d = sclk_q;
        end
      end
      S_DONE: begin
        state_d = S_GAP;
      end
      S_GAP: begin
        if (cnt_q == CNT_W'(CONV_GAP - 1)) begin
          state_d = bus.enable ? S_START : S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        sclk_d  = 1'b0;
      end
    endcase

    // Every state starts with a fresh divider and counter
    if (state_d != state_q) begin
      div_d = '0;
      cnt_d = '0;
    end else if (tick) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    cs_n_d = !((state_d == S_START) || (state_d == S_SETTLE) || (state_d == S_SHIFT));
    busy_d = (state_d != S_IDLE);
  end

  assign done_entry = (state_d == S_DONE) && (state_q != S_DONE);

`ifdef ADC_AVG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      avg_cnt_q <= 2'd0;
      acc_q     <= '0;
    end else begin
      avg_cnt_q <= avg_cnt_d;
      acc_q     <= acc_d;
    end
  end

  // A partial group is dropped whenever the reader goes back to IDLE
  always_comb begin
    data_d    = data_q;
    valid_d   = 1'b0;
    acc_d     = acc_q;
    avg_cnt_d = avg_cnt_q;
    acc_sum   = acc_q + {2'b00, shift_q};
    if (done_entry && (avg_cnt_q == 2'd3)) begin
      data_d    = acc_sum[DATA_W+1:2];
      valid_d   = 1'b1;
      acc_d     = '0;
      avg_cnt_d = 2'd0;
    end else if (done_entry) begin
      acc_d     = acc_sum;
      avg_cnt_d = avg_cnt_q + 2'd1;
    end else if ((state_d == S_IDLE) && (state_q != S_IDLE)) begin
      acc_d     = '0;
      avg_cnt_d = 2'd0;
    end else begin
      acc_d     = acc_q;
      avg_cnt_d = avg_cnt_q;
    end
  end
`else
  always_comb begin
    data_d  = data_q;
    valid_d = 1'b0;
    if (done_entry) begin
      data_d  = shift_q;
      valid_d = 1'b1;
    end else begin
      data_d  = data_q;
      valid_d = 1'b0;
    end
  end
`endif

  assign bus.adc_cs_n     = cs_n_q;
  assign bus.adc_sclk     = sclk_q;
  assign bus.data_out     = data_q;
  assign bus.sample_valid = valid_q;
  assign bus.busy         = busy_q;
endmodule
